char_seq_tx: RTL and testbench

CHAR_SEQ_TX -- requirements
Module: char_seq_tx

---
 rtl/char_seq_tx.sv | 116 +++++++++++
 tb/tb_char_seq_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_seq_tx.sv
// char_seq_tx: replays a stored character sequence len characters long, rpt+1 times,
// over a valid/ready stream. The sequence store is written only while idle.
module char_seq_tx #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CW-1:0]              wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic [3:0]                 rpt,
  input  logic                       start,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [CW-1:0]              o_char,
  output logic                       o_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]    rpt_q, rpt_d;

  logic [CW-1:0] mem [DEPTH];

  logic xfer;
  logic at_end;

  assign xfer   = (state_q == SEND) && o_ready;
  assign at_end = (LW'(idx_q) == (len_q - LW'(1)));

  // Sequence store: writable only in IDLE; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && (state_q == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // State and sequencing registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
    end
  end

  // Next-state logic: start capture, index advance, pass wrap and completion.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            rpt_d   = rpt;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_end) begin
            if (rpt_q != 4'd0) begin
              idx_d = '0;
              rpt_d = rpt_q - 4'd1;
            end else begin
              state_d = DONE;
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; character gated to zero outside SEND.
  assign o_valid = (state_q == SEND);
  assign o_char  = o_valid ? mem[idx_q] : '0;
  assign o_last  = o_valid && at_end && (rpt_q == 4'd0);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_char_seq_tx.sv
// Bench for char_seq_tx: scoreboard of expected characters pushed at start,
// compared against each presented character and popped on each transfer.
module tb_char_seq_tx;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [LW-1:0] len;
  logic [3:0]    rpt;
  logic          start;
  logic          o_valid;
  logic          o_ready;
  logic [CW-1:0] o_char;
  logic          o_last;
  logic          busy;
  logic          done;

  char_seq_tx #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .rpt     (rpt),
    .start   (start),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_char  (o_char),
    .o_last  (o_last),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [CW:0]   exp_q[$];
  logic [CW-1:0] tb_mem [DEPTH];

  logic          s_valid, s_done, s_busy;
  logic          prev_valid, prev_ready, prev_rst;
  logic [CW-1:0] prev_char;
  int unsigned   done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample outputs mid-cycle, score them, then move past the next edge.
  task automatic step();
    logic [CW:0] e;
    @(negedge clk);
    s_valid = o_valid;
    s_done  = done;
    s_busy  = busy;
    if (done) done_cnt++;
    if (prev_valid && !prev_ready && !prev_rst) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_char", 32'(o_char), 32'(prev_char));
    end
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_char", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q[0];
        chk("char", 32'(o_char), 32'(e[CW-1:0]));
        chk("last", 32'(o_last), 32'(e[CW]));
        if (o_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("last_no_valid", 32'(o_last), 32'd0);
    end
    prev_valid = o_valid;
    prev_ready = o_ready;
    prev_rst   = rst;
    prev_char  = o_char;
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int unsigned a, input logic [CW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tb_mem[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) write_mem(i, s[i]);
  endtask

  task automatic start_seq(input int unsigned l, input int unsigned r);
    len = LW'(l);
    rpt = 4'(r);
    for (int p = 0; p <= int'(r); p++)
      for (int i = 0; i < int'(l); i++)
        exp_q.push_back({(p == int'(r)) && (i == int'(l) - 1), tb_mem[i]});
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int unsigned budget);
    int unsigned k = 0;
    do begin
      step();
      k++;
    end while (s_busy && k < budget);
    chk(tag, 32'(s_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; rpt = '0; o_ready = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_rst = 1'b1; prev_char = '0;
    done_cnt = 0;

    // Reset, with start and wr_en held high during reset
    step();
    start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55; len = LW'(4);
    step();
    start = 1'b0; wr_en = 1'b0;
    step();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_busy",  32'(s_busy),  32'd0);
    chk("rst_done",  32'(s_done),  32'd0);
    chk("rst_char",  32'(o_char),  32'd0);
    chk("rst_last",  32'(o_last),  32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(s_busy), 32'd0);

    // JUSTMONIKA, single pass, always ready
    load_str("JUSTMONIKA");
    done_cnt = 0;
    start_seq(10, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("jm_valid", 32'(s_valid), 32'd1);
    end
    step();
    chk("jm_done",  32'(s_done),  32'd1);
    chk("jm_busy",  32'(s_busy),  32'd1);
    chk("jm_valid_off", 32'(s_valid), 32'd0);
    step();
    chk("jm_busy_low", 32'(s_busy), 32'd0);
    chk("jm_done_low", 32'(s_done), 32'd0);
    chk("jm_queue", 32'(exp_q.size()), 32'd0);
    chk("jm_done_cnt", done_cnt, 32'd1);

    // AB repeated three times with no bubbles
    load_str("AB");
    done_cnt = 0;
    start_seq(2, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ab_valid", 32'(s_valid), 32'd1);
    end
    step();
    chk("ab_done", 32'(s_done), 32'd1);
    step();
    chk("ab_busy_low", 32'(s_busy), 32'd0);
    chk("ab_queue", 32'(exp_q.size()), 32'd0);
    chk("ab_done_cnt", done_cnt, 32'd1);

    // CDEDE with backpressure pattern 1,0,0,1
    load_str("CDEDE");
    done_cnt = 0;
    start_seq(5, 0);
    pat = 4'b1001;
    for (int k = 0; k < 40 && (k == 0 || s_busy); k++) begin
      o_ready = pat[3 - (k % 4)];
      step();
    end
    o_ready = 1'b1;
    chk("cd_idle", 32'(s_busy), 32'd0);
    chk("cd_queue", 32'(exp_q.size()), 32'd0);
    chk("cd_done_cnt", done_cnt, 32'd1);

    // Zero length: straight to DONE
    done_cnt = 0;
    start_seq(0, 3);
    step();
    chk("z_valid", 32'(s_valid), 32'd0);
    chk("z_done",  32'(s_done),  32'd1);
    chk("z_busy",  32'(s_busy),  32'd1);
    step();
    chk("z_busy_low", 32'(s_busy), 32'd0);
    chk("z_done_cnt", done_cnt, 32'd1);

    // Len 25: ignored start/write in SEND, reset abort, restart from mem[0]
    for (int i = 0; i < 25; i++) write_mem(i, 8'(8'h61 + i));
    done_cnt = 0;
    start_seq(25, 0);
    start = 1'b1; len = LW'(3); wr_en = 1'b1; wr_addr = '0; wr_data = 8'h5A;
    step();
    start = 1'b0; wr_en = 1'b0;
    step();
    step();
    chk("r_busy_mid", 32'(s_busy), 32'd1);
    rst = 1'b1; o_ready = 1'b0;
    step();
    start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h23; len = LW'(25);
    step();
    chk("r_abort_valid", 32'(s_valid), 32'd0);
    chk("r_abort_done",  32'(s_done),  32'd0);
    exp_q.delete();
    start = 1'b0; wr_en = 1'b0; rst = 1'b0; o_ready = 1'b1;
    step();
    chk("r_idle_valid", 32'(s_valid), 32'd0);
    chk("r_idle_busy",  32'(s_busy),  32'd0);
    chk("r_no_done", done_cnt, 32'd0);
    start_seq(25, 0);
    step();
    chk("r_restart_char", 32'(prev_char), 32'h61);
    run_to_idle("r_finish", 40);
    chk("r_queue", 32'(exp_q.size()), 32'd0);
    chk("r_done_cnt", done_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
